// File: rtl/pulse_qualifier_pkg.sv
// Shared types and helpers for the discrete-input pulse qualifier.
// Holds the state enumeration and the saturating arithmetic used by the counters.
package pulse_qualifier_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } state_t;

  // Adds a to v and clamps the result to the largest value that fits in 'bits' bits (bits <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [31:0] a,
                                          input int unsigned bits);
    logic [32:0] sum;
    logic [32:0] maxv;
    maxv = (bits >= 32) ? 33'h0_FFFF_FFFF : ((33'd1 << bits) - 33'd1);
    sum  = {1'b0, v} + {1'b0, a};
    return (sum > maxv) ? maxv[31:0] : sum[31:0];
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned bits);
    return sat_add(v, 32'd1, bits);
  endfunction

endpackage

// File: rtl/pulse_qualifier_sync_bit.sv
// Multi-stage flop synchronizer for one asynchronous discrete input.
// Resets to 0; reusable for the other discrete inputs.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pulse_qualifier.sv
// Qualifies a stretched discrete input: minimum high time, dropout absorption,
// rise/fall strobes, measured high width and pulse/glitch counters.
module pulse_qualifier
  import pulse_qualifier_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned MIN_HIGH_CYCLES = 16,
  parameter int unsigned MIN_LOW_CYCLES  = 4,
  parameter int unsigned WIDTH_BITS      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  d,
  input  logic                  cnt_clr,
  output logic                  level,
  output logic                  rise_strobe,
  output logic                  fall_strobe,
  output logic [WIDTH_BITS-1:0] width,
  output logic                  width_valid,
  output logic [WIDTH_BITS-1:0] pulse_count,
  output logic [WIDTH_BITS-1:0] glitch_count
);

  localparam int unsigned MAX_RUN = (MIN_HIGH_CYCLES > MIN_LOW_CYCLES) ?
                                    MIN_HIGH_CYCLES : MIN_LOW_CYCLES;
  localparam int unsigned RUN_W   = $clog2(MAX_RUN + 1);

  logic                  ds;
  state_t                state;
  logic [RUN_W-1:0]      run;
  logic [RUN_W-1:0]      run_nxt;
  logic [WIDTH_BITS-1:0] wacc;
  logic [WIDTH_BITS-1:0] wacc_inc;
  logic [WIDTH_BITS-1:0] wacc_rejoin;
  logic                  pulse_inc;
  logic                  glitch_inc;
  logic                  low_done;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .q     (ds)
  );

  // A dropout that ends early is credited as high time: wacc + dropout + current sample.
  assign wacc_inc    = WIDTH_BITS'(sat_inc(32'(wacc), WIDTH_BITS));
  assign wacc_rejoin = WIDTH_BITS'(sat_add(32'(wacc), 32'(run) + 32'd1, WIDTH_BITS));

  always_comb begin
    run_nxt    = run + 1'b1;
    pulse_inc  = 1'b0;
    glitch_inc = 1'b0;
    low_done   = 1'b0;
    case (state)
      LOW:      pulse_inc = ds && (MIN_HIGH_CYCLES == 1);
      RISE_CHK: begin
        pulse_inc  = ds && (run_nxt == RUN_W'(MIN_HIGH_CYCLES));
        glitch_inc = !ds;
      end
      HIGH:     low_done = !ds && (MIN_LOW_CYCLES == 1);
      FALL_CHK: low_done = !ds && (run_nxt == RUN_W'(MIN_LOW_CYCLES));
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOW;
      run          <= '0;
      wacc         <= '0;
      level        <= 1'b0;
      rise_strobe  <= 1'b0;
      fall_strobe  <= 1'b0;
      width_valid  <= 1'b0;
      width        <= '0;
      pulse_count  <= '0;
      glitch_count <= '0;
    end else begin
      rise_strobe <= 1'b0;
      fall_strobe <= 1'b0;
      width_valid <= 1'b0;

      case (state)
        LOW: begin
          if (ds) begin
            run   <= RUN_W'(1);
            wacc  <= WIDTH_BITS'(1);
            state <= RISE_CHK;
          end
        end
        RISE_CHK: begin
          if (ds) begin
            run  <= run_nxt;
            wacc <= wacc_inc;
          end else begin
            state <= LOW;
          end
        end
        HIGH: begin
          if (ds) begin
            wacc <= wacc_inc;
          end else begin
            run   <= RUN_W'(1);
            state <= FALL_CHK;
          end
        end
        FALL_CHK: begin
          if (ds) begin
            wacc  <= wacc_rejoin;
            state <= HIGH;
          end else begin
            run <= run_nxt;
          end
        end
        default: state <= LOW;
      endcase

      if (pulse_inc) begin
        state       <= HIGH;
        level       <= 1'b1;
        rise_strobe <= 1'b1;
      end

      if (low_done) begin
        state       <= LOW;
        level       <= 1'b0;
        fall_strobe <= 1'b1;
        width_valid <= 1'b1;
        width       <= wacc;
      end

      // A clear coinciding with an event leaves that event counted.
      if (cnt_clr)        pulse_count <= WIDTH_BITS'(pulse_inc);
      else if (pulse_inc) pulse_count <= pulse_count + 1'b1;

      if (cnt_clr)         glitch_count <= WIDTH_BITS'(glitch_inc);
      else if (glitch_inc) glitch_count <= WIDTH_BITS'(sat_inc(32'(glitch_count), WIDTH_BITS));
    end
  end

endmodule

// File: tb/tb_pulse_qualifier.sv
// Directed bench for pulse_qualifier: table of pulse shapes plus hand-written
// latency, saturation, counter-clear and mid-pulse reset sequences.
module tb_pulse_qualifier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic d = 1'b0;
  logic cnt_clr = 1'b0;

  logic        level1, rise1, fall1, wv1;
  logic [15:0] width1, pcnt1, gcnt1;
  logic        level2, rise2, fall2, wv2;
  logic [3:0]  width2, pcnt2, gcnt2;

  int n_cmp = 0;
  int n_fail = 0;
  int rise_seen = 0;
  int fall_seen = 0;
  int both_seen = 0;

  always #5 clk = ~clk;

  pulse_qualifier u_dut (
    .clk(clk), .rst_n(rst_n), .d(d), .cnt_clr(cnt_clr),
    .level(level1), .rise_strobe(rise1), .fall_strobe(fall1),
    .width(width1), .width_valid(wv1), .pulse_count(pcnt1), .glitch_count(gcnt1)
  );

  pulse_qualifier #(.WIDTH_BITS(4), .MIN_HIGH_CYCLES(2)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .d(d), .cnt_clr(cnt_clr),
    .level(level2), .rise_strobe(rise2), .fall_strobe(fall2),
    .width(width2), .width_valid(wv2), .pulse_count(pcnt2), .glitch_count(gcnt2)
  );

  always @(negedge clk) begin
    if (rise1) rise_seen++;
    if (fall1) fall_seen++;
    if (rise1 && fall1) both_seen++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    d = 1'b0;
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
  endtask

  task automatic shape(input int h1, input int gap, input int h2);
    d = 1'b1; cycles(h1);
    if (gap > 0) begin
      d = 1'b0; cycles(gap);
    end
    if (h2 > 0) begin
      d = 1'b1; cycles(h2);
    end
    d = 1'b0; cycles(30);
  endtask

  typedef struct {
    int h1; int gap; int h2;
    int rises; int falls; int wid; int dpulse; int dglitch;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int r0, f0, p0, g0;

    vecs[0] = '{20, 0, 0,  1, 1, 20, 1, 0};
    vecs[1] = '{15, 0, 0,  0, 0, -1, 0, 1};
    vecs[2] = '{30, 3, 30, 1, 1, 63, 1, 0};
    vecs[3] = '{16, 0, 0,  1, 1, 16, 1, 0};
    vecs[4] = '{1,  0, 0,  0, 0, -1, 0, 1};
    vecs[5] = '{20, 4, 20, 2, 2, 20, 2, 0};

    // reset state
    #12;
    check("rst_level", level1, 0);
    check("rst_rise", rise1, 0);
    check("rst_width", width1, 0);
    check("rst_pcount", pcnt1, 0);
    check("rst_gcount", gcnt1, 0);
    rst_n = 1'b1;
    cycles(3);

    // rise latency 18 edges, fall latency 6 edges
    d = 1'b1;
    cycles(17);
    check("rise_early", rise1, 0);
    check("level_early", level1, 0);
    cycles(1);
    check("rise_at_18", rise1, 1);
    check("level_at_18", level1, 1);
    check("pcount_at_18", pcnt1, 1);
    cycles(1);
    check("rise_one_cycle", rise1, 0);
    d = 1'b0;
    cycles(5);
    check("fall_early", fall1, 0);
    check("level_hold", level1, 1);
    cycles(1);
    check("fall_at_6", fall1, 1);
    check("wvalid_at_6", wv1, 1);
    check("level_low", level1, 0);
    check("width_19", width1, 19);
    cycles(1);
    check("fall_one_cycle", fall1, 0);
    check("width_hold", width1, 19);
    cycles(10);

    // table-driven pulse shapes
    for (int i = 0; i < 6; i++) begin
      r0 = rise_seen; f0 = fall_seen; p0 = pcnt1; g0 = gcnt1;
      shape(vecs[i].h1, vecs[i].gap, vecs[i].h2);
      check($sformatf("v%0d_rises", i), rise_seen - r0, vecs[i].rises);
      check($sformatf("v%0d_falls", i), fall_seen - f0, vecs[i].falls);
      check($sformatf("v%0d_dpulse", i), int'(pcnt1) - p0, vecs[i].dpulse);
      check($sformatf("v%0d_dglitch", i), int'(gcnt1) - g0, vecs[i].dglitch);
      check($sformatf("v%0d_level", i), level1, 0);
      if (vecs[i].wid >= 0) check($sformatf("v%0d_width", i), width1, vecs[i].wid);
    end

    // saturating width on the 4-bit instance
    do_reset();
    shape(40, 0, 0);
    check("sat_width", width2, 15);
    check("sat_pcount", pcnt2, 1);
    check("sat_gcount", gcnt2, 0);

    // cnt_clr coinciding with a pulse_count increment
    do_reset();
    shape(5, 0, 0);
    for (int k = 0; k < 5; k++) shape(20, 0, 0);
    check("pre_clr_pcount", pcnt1, 5);
    check("pre_clr_gcount", gcnt1, 1);
    d = 1'b1;
    cycles(17);
    cnt_clr = 1'b1;
    cycles(1);
    cnt_clr = 1'b0;
    check("clr_rise", rise1, 1);
    check("clr_with_inc", pcnt1, 1);
    check("clr_alone", gcnt1, 0);
    d = 1'b0;
    cycles(20);
    check("post_clr_pcount", pcnt1, 1);

    // reset pulsed low while in HIGH, d still high
    d = 1'b1;
    cycles(25);
    check("pre_rst_level", level1, 1);
    f0 = fall_seen;
    rst_n = 1'b0;
    #1;
    check("mid_rst_level", level1, 0);
    check("mid_rst_width", width1, 0);
    check("mid_rst_pcount", pcnt1, 0);
    cycles(1);
    rst_n = 1'b1;
    cycles(17);
    check("re_rise_early", rise1, 0);
    cycles(1);
    check("re_rise_at_18", rise1, 1);
    check("no_fall_on_rst", fall_seen - f0, 0);
    d = 1'b0;
    cycles(20);

    check("no_coincident_strobes", both_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
